// File: rtl/multi_cpu_control.sv
// rtl/multi_cpu_control.sv - multicycle CPU control unit
// Phase FSM plus combinational datapath decode from state, opcode and ALU flags.
module multi_cpu_control (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       sign,
   output logic [2:0] state,
   output logic       PCWre,
   output logic       IRWre,
   output logic       InsMemRW,
   output logic       RegWre,
   output logic       mRD,
   output logic       mWR,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       ExtSel,
   output logic [1:0] RegDst,
   output logic       WrRegDSrc,
   output logic       DBDataSrc,
   output logic [1:0] PCSrc
);

   localparam logic [2:0] S_IF     = 3'b000;
   localparam logic [2:0] S_ID     = 3'b001;
   localparam logic [2:0] S_EXE_LS = 3'b010;
   localparam logic [2:0] S_MEM    = 3'b011;
   localparam logic [2:0] S_WB_LD  = 3'b100;
   localparam logic [2:0] S_EXE_BR = 3'b101;
   localparam logic [2:0] S_EXE_AL = 3'b110;
   localparam logic [2:0] S_WB_AL  = 3'b111;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_XORI  = 6'b010011;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLTI  = 6'b100110;
   localparam logic [5:0] OP_SLT   = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   logic       cls_jmp;
   logic       cls_br;
   logic       is_halt;
   logic       is_lw;
   logic       is_sw;
   logic       is_jal;
   logic [2:0] next_state;

   // Unknown opcodes fall into the jump class so they retire in two cycles as NOPs.
   always_comb begin
      cls_jmp = 1'b0;
      cls_br  = 1'b0;
      is_halt = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      case (opcode)
         OP_J, OP_JR, OP_JAL:       cls_jmp = 1'b1;
         OP_HALT:                   is_halt = 1'b1;
         OP_BEQ, OP_BNE, OP_BLTZ:   cls_br  = 1'b1;
         OP_SW:                     is_sw   = 1'b1;
         OP_LW:                     is_lw   = 1'b1;
         OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI,
         OP_XORI, OP_SLL, OP_SLTI, OP_SLT: ;
         default:                   cls_jmp = 1'b1;
      endcase
      is_jal = (opcode == OP_JAL);
   end

   always_comb begin
      next_state = S_IF;
      case (state)
         S_IF:     next_state = S_ID;
         S_ID: begin
            if (is_halt)             next_state = S_ID;
            else if (cls_jmp)        next_state = S_IF;
            else if (cls_br)         next_state = S_EXE_BR;
            else if (is_lw || is_sw) next_state = S_EXE_LS;
            else                     next_state = S_EXE_AL;
         end
         S_EXE_LS: next_state = S_MEM;
         S_MEM:    next_state = is_lw ? S_WB_LD : S_IF;
         S_WB_LD:  next_state = S_IF;
         S_EXE_BR: next_state = S_IF;
         S_EXE_AL: next_state = S_WB_AL;
         S_WB_AL:  next_state = S_IF;
         default:  next_state = S_IF;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= S_IF;
      else       state <= next_state;
   end

   // PCWre fires only in the final state of each instruction, giving one pulse per instruction.
   always_comb begin
      IRWre    = (state == S_IF);
      InsMemRW = (state == S_IF);
      PCWre    = ((state == S_ID) && cls_jmp) || (state == S_EXE_BR) ||
                 ((state == S_MEM) && is_sw) || (state == S_WB_AL) || (state == S_WB_LD);
      RegWre   = (state == S_WB_AL) || (state == S_WB_LD) || ((state == S_ID) && is_jal);
      mRD      = (state == S_MEM) && is_lw;
      mWR      = (state == S_MEM) && is_sw;
   end

   always_comb begin
      ALUOp     = 3'b000;
      ALUSrcA   = (opcode == OP_SLL);
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b1;
      RegDst    = 2'b01;
      WrRegDSrc = !is_jal;
      DBDataSrc = is_lw;
      PCSrc     = 2'b00;
      case (opcode)
         OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ALUOp = 3'b001;
         OP_SLL:                          ALUOp = 3'b010;
         OP_ORI:                          ALUOp = 3'b011;
         OP_AND, OP_ANDI:                 ALUOp = 3'b100;
         OP_SLT, OP_SLTI:                 ALUOp = 3'b110;
         OP_XORI:                         ALUOp = 3'b111;
         default:                         ALUOp = 3'b000;
      endcase
      case (opcode)
         OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LW, OP_SW: ALUSrcB = 1'b1;
         default: ALUSrcB = 1'b0;
      endcase
      case (opcode)
         OP_ANDI, OP_ORI, OP_XORI: ExtSel = 1'b0;
         default:                  ExtSel = 1'b1;
      endcase
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL: RegDst = 2'b10;
         OP_JAL:                                 RegDst = 2'b00;
         default:                                RegDst = 2'b01;
      endcase
      case (opcode)
         OP_J, OP_JAL: PCSrc = 2'b11;
         OP_JR:        PCSrc = 2'b10;
         OP_BEQ:       PCSrc = zero  ? 2'b01 : 2'b00;
         OP_BNE:       PCSrc = !zero ? 2'b01 : 2'b00;
         OP_BLTZ:      PCSrc = sign  ? 2'b01 : 2'b00;
         default:      PCSrc = 2'b00;
      endcase
   end

endmodule

// File: doc/multi_cpu_control.md
# multi_cpu_control

Control unit of the multicycle CPU. Holds the instruction-phase state machine (IF, ID, EXE, MEM, WB) and drives the shared datapath from the current opcode and the ALU `zero`/`sign` flags. Datapath controls include ALU operation and operand selects, register-file, memory, IR and PC write enables, and next-PC selection. It sits between the instruction register and the datapath and is the only block that decides when each datapath register updates.

## Interface
Parameters:
- none; opcode map and state encoding are fixed below.

Ports:
- `CLK` in 1: system clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-high; forces the state to IF.
- `opcode` in 6: `IR[31:26]` of the current instruction.
- `zero` in 1: ALU result==0, valid in EXE_BR.
- `sign` in 1: ALU `result[31]`, valid in EXE_BR.
- `state` out 3: current state, for debug and display.
- `PCWre` out 1: PC write enable.
- `IRWre` out 1: IR write enable.
- `InsMemRW` out 1: instruction memory read.
- `RegWre` out 1: register-file write enable.
- `mRD` out 1: data memory read.
- `mWR` out 1: data memory write.
- `ALUSrcA` out 1: ALU A operand. 0 = rs; 1 = zero-extended shamt.
- `ALUSrcB` out 1: ALU B operand. 0 = rt; 1 = extended imm16.
- `ALUOp` out 3: 000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 sltu, 110 slt, 111 xor.
- `ExtSel` out 1: 1 = sign-extend imm16; 0 = zero-extend.
- `RegDst` out 2: write register. 00 = $31, 01 = rt, 10 = rd.
- `WrRegDSrc` out 1: write data. 0 = PC+4 (jal); 1 = DB.
- `DBDataSrc` out 1: DB source. 0 = ALU result; 1 = data memory.
- `PCSrc` out 2: next PC. 00 = PC+4, 01 = PC+4+(sext imm<<2), 10 = rs, 11 = {PC+4[31:28], addr26, 00}.

## Operation
- Opcodes:
  - add 000000, sub 000001, addiu 000010
  - and 010000, andi 010001, ori 010010, xori 010011
  - sll 011000, slti 100110, slt 100111
  - sw 110000, lw 110001
  - beq 110100, bne 110101, bltz 110110
  - j 111000, jr 111001, jal 111010, halt 111111
- Any other opcode is a NOP: treated like j with PCSrc=00.
- State encoding: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Transitions:
  - IF -> ID.
  - ID -> IF for j, jr, jal and NOP.
  - ID -> ID for halt; the FSM stays there until Reset.
  - ID -> EXE_BR for beq, bne, bltz; EXE_BR -> IF.
  - ID -> EXE_LS for lw, sw; EXE_LS -> MEM.
  - MEM -> IF for sw; MEM -> WB_LD for lw; WB_LD -> IF.
  - ID -> EXE_AL for all remaining ops; EXE_AL -> WB_AL -> IF.
- Write enables are decoded from state and opcode:
  - IRWre=1 and InsMemRW=1 only in IF.
  - PCWre=1 only in the last state of each instruction: ID (j/jr/jal/NOP), EXE_BR, MEM (sw), WB_AL, WB_LD. Never for halt.
  - RegWre=1 in WB_AL, in WB_LD, and in ID for jal.
  - mRD=1 in MEM for lw; mWR=1 in MEM for sw.
- Steering outputs are decoded from opcode alone, in every state:
  - ALUOp:
    - add, addiu, lw, sw -> 000
    - sub, beq, bne, bltz -> 001
    - sll -> 010
    - ori -> 011
    - and, andi -> 100
    - slt, slti -> 110
    - xori -> 111
  - ALUSrcA=1 only for sll.
  - ALUSrcB=1 for addiu, andi, ori, xori, slti, lw, sw.
  - ExtSel=0 for andi, ori, xori; 1 otherwise.
  - RegDst: 10 for R-type (add, sub, and, slt, sll); 00 for jal; 01 otherwise.
  - WrRegDSrc=0 only for jal. DBDataSrc=1 only for lw.
- PCSrc:
  - j, jal -> 11; jr -> 10.
  - beq -> 01 if `zero`; bne -> 01 if `!zero`; bltz -> 01 if `sign` (rt field is $0 by ISA); otherwise 00.
  - All other opcodes -> 00.
- Unused outputs hold their decoded value and are not forced to 0; their effect is masked by the enables.

## Timing
- Only `state` is registered; all outputs are combinational from state, opcode, zero and sign.
- Reset:
  - Asserting Reset at any time, including mid-instruction, immediately forces state=IF.
  - IRWre=1 and InsMemRW=1 while Reset is held.
  - PCWre, RegWre, mRD, mWR = 0 while Reset is held.
  - The first edge after release moves IF -> ID.
- Cycles per instruction: j/jr/jal/NOP 2, branch 3, sw 4, ALU ops 4, lw 5.
- Exactly one PCWre pulse per instruction, one cycle wide; none while halted.
- zero and sign are only consumed in EXE_BR, in the same cycle they are produced.

## Test plan
- Reset asserted in WB_AL mid-add -> state=000 without a clock edge; RegWre=0, PCWre=0.
- add (000000) -> states 000,001,110,111,000; RegWre=1 and PCWre=1 only in 111; RegDst=10, ALUOp=000.
- lw (110001) -> states 000,001,010,011,100,000; mRD=1 in 011; RegWre=1, DBDataSrc=1 and RegDst=01 in 100.
- beq with zero=1, then with zero=0 -> PCSrc=01 then 00 in state 101; PCWre=1 in both; bltz with sign=1 -> PCSrc=01.
- jal (111010) -> 2 cycles; in state 001: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- halt (111111) -> state stays 001 for 20 cycles with all enables 0; Reset pulse -> state 000.
